sobel_window_fetch: RTL and testbench

Fetches and maintains the 3x3 pixel neighbourhood for the Sobel stage, directly downstream of the serpentine address generator. On a full load it reads all 9 pixels around a centre address. On each single-pixel move (right, left or down) it shifts the held window and reads only the 3 newly exposed pixels. It drives a single-port image SRAM with 1-cycle read latency and presents a flattened window plus a valid flag to the gradient compute.

---
 rtl/sobel_window_fetch.sv | 193 +++++++++++++++++++
 tb/tb_sobel_window_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_fetch.sv
// 3x3 neighbourhood fetcher for the Sobel stage: full 9-pixel loads or 3-pixel
// shift-fills after a single-step move, reading a 1-cycle-latency single-port SRAM.
module sobel_window_fetch #(
    parameter int ADDR_W = 8,
    parameter int PIX_W  = 8
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [11:0]          length,
    input  logic [ADDR_W-1:0]    center_addr,
    input  logic [1:0]           direction,
    input  logic                 load_full,
    input  logic                 load_shift,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_ren,
    input  logic [PIX_W-1:0]     mem_rdata,
    output logic [9*PIX_W-1:0]   window,
    output logic                 window_valid,
    output logic                 busy,
    output logic                 fill_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] M_FULL  = 2'b00;
    localparam logic [1:0] M_RIGHT = 2'b01;
    localparam logic [1:0] M_LEFT  = 2'b10;
    localparam logic [1:0] M_DOWN  = 2'b11;

    // Row/column {r,c} of the k-th read for a given fill mode.
    function automatic logic [3:0] rc_of(input logic [1:0] mode, input logic [3:0] k);
        logic [1:0] r;
        logic [1:0] c;
        case (mode)
            M_RIGHT: begin r = k[1:0]; c = 2'd2;   end
            M_LEFT:  begin r = k[1:0]; c = 2'd0;   end
            M_DOWN:  begin r = 2'd2;   c = k[1:0]; end
            default: begin
                r = (k >= 4'd6) ? 2'd2 : ((k >= 4'd3) ? 2'd1 : 2'd0);
                c = 2'(k - 4'd3 * {2'b00, r});
            end
        endcase
        return {r, c};
    endfunction

    function automatic logic [3:0] slot_idx(input logic [3:0] rc);
        return 4'd3 * {2'b00, rc[3:2]} + {2'b00, rc[1:0]};
    endfunction

    // Address math wraps modulo 2^ADDR_W on purpose; edges are the generator's job.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [3:0] rc,
                                                  input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] len);
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] res;
        case (rc[3:2])
            2'd0:    row = base - len;
            2'd1:    row = base;
            default: row = base + len;
        endcase
        case (rc[1:0])
            2'd0:    res = row - ADDR_W'(1);
            2'd1:    res = row;
            default: res = row + ADDR_W'(1);
        endcase
        return res;
    endfunction

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [3:0]          r_last;
    logic [1:0]          r_mode;
    logic [ADDR_W-1:0]   r_center;
    logic [ADDR_W-1:0]   r_len;
    logic                r_cap_vld;
    logic [3:0]          r_cap_slot;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_ren;
    logic [9*PIX_W-1:0]  r_window;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;

    logic                w_req;
    logic [1:0]          w_mode;
    logic [ADDR_W-1:0]   w_len;
    logic [9*PIX_W-1:0]  w_shifted;
    logic                w_len_unused;

    assign w_req        = load_full | load_shift;
    assign w_mode       = (load_full || direction == 2'b00) ? M_FULL : direction;
    assign w_len        = length[ADDR_W-1:0];
    assign w_len_unused = ^length[11:ADDR_W];

    // Window contents after the accept-edge shift for the requested move.
    always_comb begin
        w_shifted = r_window;
        for (int r = 0; r < 3; r++) begin
            case (w_mode)
                M_RIGHT: begin
                    w_shifted[(3*r)*PIX_W   +: PIX_W] = r_window[(3*r+1)*PIX_W +: PIX_W];
                    w_shifted[(3*r+1)*PIX_W +: PIX_W] = r_window[(3*r+2)*PIX_W +: PIX_W];
                end
                M_LEFT: begin
                    w_shifted[(3*r+2)*PIX_W +: PIX_W] = r_window[(3*r+1)*PIX_W +: PIX_W];
                    w_shifted[(3*r+1)*PIX_W +: PIX_W] = r_window[(3*r)*PIX_W   +: PIX_W];
                end
                M_DOWN: begin
                    w_shifted[r*PIX_W     +: PIX_W] = r_window[(r+3)*PIX_W +: PIX_W];
                    w_shifted[(r+3)*PIX_W +: PIX_W] = r_window[(r+6)*PIX_W +: PIX_W];
                end
                default: begin
                    w_shifted = r_window;
                end
            endcase
        end
    end

    // Fill FSM: accept, issue one read per cycle, capture data one cycle later.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_last     <= 4'd0;
            r_mode     <= M_FULL;
            r_center   <= '0;
            r_len      <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_slot <= 4'd0;
            r_mem_addr <= '0;
            r_mem_ren  <= 1'b0;
            r_window   <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_cap_vld) begin
                r_window[r_cap_slot*PIX_W +: PIX_W] <= mem_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_mode     <= w_mode;
                        r_center   <= center_addr;
                        r_len      <= w_len;
                        r_valid    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_mem_ren  <= 1'b1;
                        r_mem_addr <= addr_of(rc_of(w_mode, 4'd0), center_addr, w_len);
                        r_cnt      <= 4'd0;
                        r_last     <= (w_mode == M_FULL) ? 4'd8 : 4'd2;
                        r_window   <= w_shifted;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cap_vld  <= 1'b1;
                    r_cap_slot <= slot_idx(rc_of(r_mode, r_cnt));
                    if (r_cnt == r_last) begin
                        r_mem_ren <= 1'b0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_cnt      <= r_cnt + 4'd1;
                        r_mem_addr <= addr_of(rc_of(r_mode, r_cnt + 4'd1), r_center, r_len);
                    end
                end
                S_DRAIN: begin
                    r_cap_vld <= 1'b0;
                    r_busy    <= 1'b0;
                    r_valid   <= 1'b1;
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_ren      = r_mem_ren;
    assign window       = r_window;
    assign window_valid = r_valid;
    assign busy         = r_busy;
    assign fill_done    = r_done;

endmodule

// File: tb/tb_sobel_window_fetch.sv
// Scoreboard bench for sobel_window_fetch: expected read addresses are queued
// per request and compared against the reads the DUT actually issues.
module tb_sobel_window_fetch;

    logic         clk = 1'b0;
    logic         n_reset;
    logic [11:0]  length;
    logic [7:0]   center_addr;
    logic [1:0]   direction;
    logic         load_full;
    logic         load_shift;
    logic [7:0]   mem_addr;
    logic         mem_ren;
    logic [7:0]   mem_rdata = 8'd0;
    logic [71:0]  window;
    logic         window_valid;
    logic         busy;
    logic         fill_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int done_total = 0;
    int obs_q[$];
    int obs_cyc[$];
    int exp_q[$];
    int t_acc;
    int t_done;
    bit ok;
    logic v_t1;
    logic b_t1;

    sobel_window_fetch #(.ADDR_W(8), .PIX_W(8)) dut (
        .clk(clk), .n_reset(n_reset), .length(length), .center_addr(center_addr),
        .direction(direction), .load_full(load_full), .load_shift(load_shift),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
        .window(window), .window_valid(window_valid), .busy(busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Image memory: mem[a] = a, one cycle read latency.
    always @(posedge clk) if (mem_ren === 1'b1) mem_rdata <= mem_addr;

    // Read/completion monitor feeding the scoreboard.
    always @(negedge clk) begin
        if (mem_ren === 1'b1) begin
            obs_q.push_back(int'(mem_addr));
            obs_cyc.push_back(cyc);
        end
        if (fill_done === 1'b1) done_total++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no summary before time limit, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] win9(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6, input int a7, input int a8);
        return {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    task automatic push9(input int a0, input int a1, input int a2, input int a3, input int a4,
                         input int a5, input int a6, input int a7, input int a8);
        exp_q = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    endtask

    // Drive one request and wait (bounded) for fill_done.
    task automatic run_req(input logic f, input logic s, input logic [1:0] d,
                           input logic [7:0] c, input bit now);
        obs_q.delete();
        obs_cyc.delete();
        if (!now) @(negedge clk);
        load_full = f; load_shift = s; direction = d; center_addr = c;
        t_acc = cyc;
        @(negedge clk);
        load_full = 1'b0; load_shift = 1'b0;
        v_t1 = window_valid; b_t1 = busy;
        ok = 1'b0; t_done = -1;
        for (int i = 0; i < 30; i++) begin
            if (fill_done === 1'b1) begin
                ok = 1'b1; t_done = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        n_reset = 1'b0; length = 12'd10; center_addr = 8'd0; direction = 2'b00;
        load_full = 1'b0; load_shift = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (mem_addr !== 8'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
        tests++; if (mem_ren !== 1'b0) begin fails++; $display("FAIL reset_ren: got %b want 0", mem_ren); end
        tests++; if (window !== 72'd0) begin fails++; $display("FAIL reset_window: got %h want 0", window); end
        tests++; if ({window_valid, busy, fill_done} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {window_valid, busy, fill_done}); end
        n_reset = 1'b1;
    endtask

    task automatic test_full;
        push9(0, 1, 2, 10, 11, 12, 20, 21, 22);
        run_req(1'b1, 1'b0, 2'b00, 8'd11, 1'b0);
        tests++; if (ok !== 1'b1 || t_done !== t_acc + 11) begin fails++; $display("FAIL full_done_time: got %0d want %0d", t_done - t_acc, 11); end
        tests++; if (b_t1 !== 1'b1) begin fails++; $display("FAIL full_busy: got %b want 1", b_t1); end
        tests++; if (obs_q.size() !== 9 || obs_cyc[0] !== t_acc + 1) begin fails++; $display("FAIL full_reads: got %0d reads want 9 from T+1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front(); int o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL full_addr: got %0d want %0d", o, e); end
        end
        tests++; if (window !== win9(0, 1, 2, 10, 11, 12, 20, 21, 22)) begin fails++; $display("FAIL full_window: got %h", window); end
        tests++; if (window_valid !== 1'b1) begin fails++; $display("FAIL full_valid: got %b want 1", window_valid); end
        @(negedge clk);
        tests++; if (fill_done !== 1'b0 || window_valid !== 1'b1) begin fails++; $display("FAIL full_pulse: got done=%b valid=%b want 0/1", fill_done, window_valid); end
        exp_q.delete();
    endtask

    task automatic test_right;
        exp_q = '{3, 13, 23};
        run_req(1'b0, 1'b1, 2'b01, 8'd12, 1'b0);
        tests++; if (ok !== 1'b1 || t_done !== t_acc + 5) begin fails++; $display("FAIL right_done_time: got %0d want 5", t_done - t_acc); end
        tests++; if (v_t1 !== 1'b0) begin fails++; $display("FAIL right_valid_clear: got %b want 0", v_t1); end
        tests++; if (obs_q.size() !== 3) begin fails++; $display("FAIL right_nreads: got %0d want 3", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front(); int o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL right_addr: got %0d want %0d", o, e); end
        end
        tests++; if (window !== win9(1, 2, 3, 11, 12, 13, 21, 22, 23)) begin fails++; $display("FAIL right_window: got %h", window); end
        exp_q.delete();
    endtask

    task automatic test_down_left;
        run_req(1'b1, 1'b0, 2'b00, 8'd18, 1'b0);
        tests++; if (window !== win9(7, 8, 9, 17, 18, 19, 27, 28, 29)) begin fails++; $display("FAIL down_setup: got %h", window); end
        exp_q = '{37, 38, 39};
        run_req(1'b0, 1'b1, 2'b11, 8'd28, 1'b0);
        tests++; if (ok !== 1'b1 || obs_q.size() !== 3) begin fails++; $display("FAIL down_nreads: got %0d want 3", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front(); int o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL down_addr: got %0d want %0d", o, e); end
        end
        tests++; if (window !== win9(17, 18, 19, 27, 28, 29, 37, 38, 39)) begin fails++; $display("FAIL down_window: got %h", window); end
        exp_q = '{16, 26, 36};
        run_req(1'b0, 1'b1, 2'b10, 8'd27, 1'b0);
        tests++; if (ok !== 1'b1 || obs_q.size() !== 3) begin fails++; $display("FAIL left_nreads: got %0d want 3", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front(); int o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL left_addr: got %0d want %0d", o, e); end
        end
        tests++; if (window !== win9(16, 17, 18, 26, 27, 28, 36, 37, 38)) begin fails++; $display("FAIL left_window: got %h", window); end
        exp_q.delete();
    endtask

    task automatic test_wrap;
        push9(245, 246, 247, 255, 0, 1, 9, 10, 11);
        run_req(1'b1, 1'b0, 2'b00, 8'd0, 1'b0);
        tests++; if (ok !== 1'b1 || obs_q.size() !== 9) begin fails++; $display("FAIL wrap_nreads: got %0d want 9", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front(); int o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL wrap_addr: got %0d want %0d", o, e); end
        end
        tests++; if (window !== win9(245, 246, 247, 255, 0, 1, 9, 10, 11)) begin fails++; $display("FAIL wrap_window: got %h", window); end
    endtask

    task automatic test_ignore_busy;
        fork
            run_req(1'b1, 1'b0, 2'b00, 8'd11, 1'b0);
            begin
                repeat (3) @(negedge clk);
                load_shift = 1'b1; direction = 2'b01;
                @(negedge clk);
                load_shift = 1'b0;
            end
        join
        tests++; if (ok !== 1'b1 || t_done !== t_acc + 11) begin fails++; $display("FAIL ignore_done_time: got %0d want 11", t_done - t_acc); end
        tests++; if (obs_q.size() !== 9) begin fails++; $display("FAIL ignore_nreads: got %0d want 9", obs_q.size()); end
        tests++; if (window !== win9(0, 1, 2, 10, 11, 12, 20, 21, 22)) begin fails++; $display("FAIL ignore_window: got %h", window); end
    endtask

    task automatic test_priority_back_to_back;
        run_req(1'b1, 1'b1, 2'b01, 8'd22, 1'b0);
        tests++; if (obs_q.size() !== 9 || t_done !== t_acc + 11) begin fails++; $display("FAIL both_full: got %0d reads want 9", obs_q.size()); end
        tests++; if (window !== win9(11, 12, 13, 21, 22, 23, 31, 32, 33)) begin fails++; $display("FAIL both_window: got %h", window); end
        run_req(1'b0, 1'b1, 2'b00, 8'd11, 1'b0);
        tests++; if (obs_q.size() !== 9 || t_done !== t_acc + 11) begin fails++; $display("FAIL dir0_full: got %0d reads want 9", obs_q.size()); end
        tests++; if (window !== win9(0, 1, 2, 10, 11, 12, 20, 21, 22)) begin fails++; $display("FAIL dir0_window: got %h", window); end
        exp_q = '{3, 13, 23};
        run_req(1'b0, 1'b1, 2'b01, 8'd12, 1'b1);
        tests++; if (ok !== 1'b1 || t_done !== t_acc + 5 || b_t1 !== 1'b1) begin fails++; $display("FAIL b2b_accept: got done at %0d want 5", t_done - t_acc); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front(); int o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL b2b_addr: got %0d want %0d", o, e); end
        end
        tests++; if (window !== win9(1, 2, 3, 11, 12, 13, 21, 22, 23)) begin fails++; $display("FAIL b2b_window: got %h", window); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_fill;
        int t0;
        int dsnap;
        @(negedge clk);
        load_full = 1'b1; center_addr = 8'd11; t0 = cyc;
        @(negedge clk);
        load_full = 1'b0;
        repeat (4) @(negedge clk);
        n_reset = 1'b0; dsnap = done_total;
        @(negedge clk);
        tests++; if (mem_addr !== 8'd0 || mem_ren !== 1'b0) begin fails++; $display("FAIL midrst_mem: got addr=%0d ren=%b want 0/0", mem_addr, mem_ren); end
        tests++; if (window !== 72'd0) begin fails++; $display("FAIL midrst_window: got %h want 0", window); end
        tests++; if ({window_valid, busy, fill_done} !== 3'b000) begin fails++; $display("FAIL midrst_flags: got %b want 000", {window_valid, busy, fill_done}); end
        n_reset = 1'b1;
        @(negedge clk);
        tests++; if (cyc !== t0 + 7 || window !== 72'd0 || done_total !== dsnap) begin fails++; $display("FAIL midrst_quiet: got cyc=%0d done=%0d want %0d/%0d", cyc - t0, done_total - dsnap, 7, 0); end
        push9(0, 1, 2, 10, 11, 12, 20, 21, 22);
        run_req(1'b1, 1'b0, 2'b00, 8'd11, 1'b1);
        tests++; if (ok !== 1'b1 || t_done !== t0 + 18 || obs_q.size() !== 9) begin fails++; $display("FAIL midrst_restart: got done at %0d want %0d", t_done - t0, 18); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            int e = exp_q.pop_front(); int o = obs_q.pop_front();
            tests++; if (o !== e) begin fails++; $display("FAIL midrst_addr: got %0d want %0d", o, e); end
        end
        tests++; if (window !== win9(0, 1, 2, 10, 11, 12, 20, 21, 22)) begin fails++; $display("FAIL midrst_window2: got %h", window); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_full();
        test_right();
        test_down_left();
        test_wrap();
        test_ignore_busy();
        test_priority_back_to_back();
        test_reset_mid_fill();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
